// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// MUL runs as an N-step shift-add and DIVU/REMU as an N-step restoring
// divide. Every other opcode completes straight from IDLE into DONE.
// Build option: define SEQ_ALU_DIV_EN to include the divider, the DIVU/REMU
// opcodes and divide-by-zero handling. Without it, 0x16/0x17 are illegal.
module seq_alu #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   num1,
   input  logic [N-1:0]   num2,
   input  logic [4:0]     operation,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   results,
   output logic [2*N-1:0] xresults,
   output logic           carryflag,
   output logic           overflow,
   output logic           zeroflag,
   output logic           negflag,
   output logic           errflag
);

   localparam int SW = $clog2(N);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [4:0] OP_ADD  = 5'h00, OP_SUB  = 5'h01, OP_INC  = 5'h02;
   localparam logic [4:0] OP_DEC  = 5'h03, OP_MUL  = 5'h04, OP_OR   = 5'h05;
   localparam logic [4:0] OP_AND  = 5'h06, OP_XOR  = 5'h07, OP_NOR  = 5'h08;
   localparam logic [4:0] OP_NAND = 5'h09, OP_XNOR = 5'h0A, OP_NOT  = 5'h0B;
   localparam logic [4:0] OP_SHL1 = 5'h0C, OP_SHR1 = 5'h0D, OP_ASR1 = 5'h0E;
   localparam logic [4:0] OP_ROL1 = 5'h0F, OP_ROR1 = 5'h10, OP_EQ   = 5'h11;
   localparam logic [4:0] OP_GT   = 5'h12, OP_LT   = 5'h13, OP_GE   = 5'h14;
   localparam logic [4:0] OP_LE   = 5'h15, OP_SHLV = 5'h18, OP_ASRV = 5'h19;
`ifdef SEQ_ALU_DIV_EN
   localparam logic [4:0] OP_DIVU = 5'h16, OP_REMU = 5'h17;
`endif

   logic [1:0]    state;
   logic [SW-1:0] stepCnt;
   logic [N-1:0]  bReg;
   logic [N-1:0]  workHi;
   logic [N-1:0]  workLo;
`ifdef SEQ_ALU_DIV_EN
   logic [4:0]    opReg;
`endif

   logic [N:0]     calcSum;
   logic [N-1:0]   calcResults;
   logic [2*N-1:0] calcX;
   logic           calcCarry, calcOvf, calcErr, calcExec, calcIllegal;
   logic           calcZero, calcNeg;
   logic [SW-1:0]  shiftAmt;

   logic [N:0]     mulSum;
   logic [N-1:0]   nxtHi, nxtLo;
   logic [N-1:0]   finResults;
   logic [2*N-1:0] finX;
   logic           finZero, finNeg;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign shiftAmt  = num2[SW-1:0];

   // One shift-add step: {workHi, workLo} is the running product register.
   assign mulSum = {1'b0, workHi} + (workLo[0] ? {1'b0, bReg} : {(N+1){1'b0}});

`ifdef SEQ_ALU_DIV_EN
   logic [N:0]   divShift, divDiff;
   logic         divGe;
   logic [N-1:0] divHi, divLo;

   // One restoring-divide step: workHi is the partial remainder, workLo the
   // dividend shifting out while quotient bits shift in.
   assign divShift = {workHi, workLo[N-1]};
   assign divDiff  = divShift - {1'b0, bReg};
   assign divGe    = ~divDiff[N];
   assign divHi    = divGe ? divDiff[N-1:0] : divShift[N-1:0];
   assign divLo    = {workLo[N-2:0], divGe};
`endif

   // Next iteration state and the final result values for the iterative ops.
   always_comb begin
      nxtHi      = mulSum[N:1];
      nxtLo      = {mulSum[0], workLo[N-1:1]};
      finResults = nxtLo;
      finX       = {nxtHi, nxtLo};
      finZero    = (finX == '0);
      finNeg     = finX[2*N-1];
`ifdef SEQ_ALU_DIV_EN
      if (opReg != OP_MUL) begin
         nxtHi      = divHi;
         nxtLo      = divLo;
         finResults = (opReg == OP_REMU) ? divHi : divLo;
         finX       = {divHi, divLo};
         finZero    = (finResults == '0);
         finNeg     = finResults[N-1];
      end
`endif
   end

   // Single-cycle results computed straight from the offered operands.
   always_comb begin
      calcSum     = '0;
      calcResults = '0;
      calcX       = '0;
      calcCarry   = 1'b0;
      calcOvf     = 1'b0;
      calcErr     = 1'b0;
      calcExec    = 1'b0;
      calcIllegal = 1'b0;
      case (operation)
         OP_ADD: begin
            calcSum     = {1'b0, num1} + {1'b0, num2};
            calcResults = calcSum[N-1:0];
            calcCarry   = calcSum[N];
            calcOvf     = (num1[N-1] == num2[N-1]) && (calcSum[N-1] != num1[N-1]);
         end
         OP_SUB: begin
            calcSum     = {1'b0, num1} - {1'b0, num2};
            calcResults = calcSum[N-1:0];
            calcCarry   = calcSum[N];
            calcOvf     = (num1[N-1] != num2[N-1]) && (calcSum[N-1] != num1[N-1]);
         end
         OP_INC: begin
            calcSum     = {1'b0, num1} + (N+1)'(1);
            calcResults = calcSum[N-1:0];
            calcCarry   = calcSum[N];
         end
         OP_DEC: begin
            calcSum     = {1'b0, num1} - (N+1)'(1);
            calcResults = calcSum[N-1:0];
            calcCarry   = calcSum[N];
         end
         OP_MUL:  calcExec = 1'b1;
         OP_OR:   calcResults = num1 | num2;
         OP_AND:  calcResults = num1 & num2;
         OP_XOR:  calcResults = num1 ^ num2;
         OP_NOR:  calcResults = ~(num1 | num2);
         OP_NAND: calcResults = ~(num1 & num2);
         OP_XNOR: calcResults = ~(num1 ^ num2);
         OP_NOT:  calcResults = ~num1;
         OP_SHL1: calcResults = {num1[N-2:0], 1'b0};
         OP_SHR1: calcResults = {1'b0, num1[N-1:1]};
         OP_ASR1: calcResults = {num1[N-1], num1[N-1:1]};
         OP_ROL1: calcResults = {num1[N-2:0], num1[N-1]};
         OP_ROR1: calcResults = {num1[0], num1[N-1:1]};
         OP_EQ:   calcResults = {{(N-1){1'b0}}, num1 == num2};
         OP_GT:   calcResults = {{(N-1){1'b0}}, num1 >  num2};
         OP_LT:   calcResults = {{(N-1){1'b0}}, num1 <  num2};
         OP_GE:   calcResults = {{(N-1){1'b0}}, num1 >= num2};
         OP_LE:   calcResults = {{(N-1){1'b0}}, num1 <= num2};
         OP_SHLV: calcResults = num1 << shiftAmt;
         OP_ASRV: calcResults = $signed(num1) >>> shiftAmt;
`ifdef SEQ_ALU_DIV_EN
         OP_DIVU, OP_REMU: begin
            if (num2 == '0) begin
               calcResults = (operation == OP_DIVU) ? {N{1'b1}} : num1;
               calcX       = {num1, {N{1'b1}}};
               calcErr     = 1'b1;
            end else begin
               calcExec = 1'b1;
            end
         end
`endif
         default: begin
            calcErr     = 1'b1;
            calcIllegal = 1'b1;
         end
      endcase
      calcZero = !calcIllegal && (calcResults == '0);
      calcNeg  = calcResults[N-1];
   end

   // Control FSM, iteration registers and the held result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         stepCnt   <= '0;
         bReg      <= '0;
         workHi    <= '0;
         workLo    <= '0;
`ifdef SEQ_ALU_DIV_EN
         opReg     <= '0;
`endif
         results   <= '0;
         xresults  <= '0;
         carryflag <= 1'b0;
         overflow  <= 1'b0;
         zeroflag  <= 1'b0;
         negflag   <= 1'b0;
         errflag   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  bReg    <= num2;
                  stepCnt <= '0;
`ifdef SEQ_ALU_DIV_EN
                  opReg   <= operation;
`endif
                  if (calcExec) begin
                     workHi <= '0;
                     workLo <= num1;
                     state  <= EXEC;
                  end else begin
                     results   <= calcResults;
                     xresults  <= calcX;
                     carryflag <= calcCarry;
                     overflow  <= calcOvf;
                     zeroflag  <= calcZero;
                     negflag   <= calcNeg;
                     errflag   <= calcErr;
                     state     <= DONE;
                  end
               end
            end
            EXEC: begin
               workHi  <= nxtHi;
               workLo  <= nxtLo;
               stepCnt <= stepCnt + SW'(1);
               if (stepCnt == SW'(N-1)) begin
                  results   <= finResults;
                  xresults  <= finX;
                  carryflag <= 1'b0;
                  overflow  <= 1'b0;
                  zeroflag  <= finZero;
                  negflag   <= finNeg;
                  errflag   <= 1'b0;
                  stepCnt   <= '0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (N=8). Expected values are hand-computed.
// Define SEQ_ALU_DIV_EN for both RTL and bench to cover the divider.
module tb_seq_alu;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   num1;
   logic [N-1:0]   num2;
   logic [4:0]     operation;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   results;
   logic [2*N-1:0] xresults;
   logic           carryflag, overflow, zeroflag, negflag, errflag;

   int checkCount = 0;
   int errorCount = 0;

   seq_alu #(.N(N)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .num1(num1), .num2(num2), .operation(operation),
      .out_valid(out_valid), .out_ready(out_ready),
      .results(results), .xresults(xresults),
      .carryflag(carryflag), .overflow(overflow), .zeroflag(zeroflag),
      .negflag(negflag), .errflag(errflag)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Offer one operation, complete the input handshake, then scramble inputs.
   task automatic applyStimulus(input logic [4:0] op, input logic [N-1:0] a,
                                input logic [N-1:0] b);
      @(negedge clk);
      operation = op;
      num1      = a;
      num2      = b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      num1      = 8'hA5;
      num2      = 8'h5A;
      operation = 5'h1F;
   endtask

   // Count edges after the accept edge until out_valid, watching in_ready.
   task automatic waitResult(output int edges, output bit busySeen);
      edges    = 0;
      busySeen = 1'b0;
      while (out_valid !== 1'b1 && edges < 60) begin
         if (in_ready !== 1'b0) busySeen = 1'b1;
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   // Accept the pending result with a one-cycle out_ready pulse.
   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   // Full transaction with checks; expFlags = {carry, ovf, zero, neg, err}.
   task automatic runOp(input string tag, input logic [4:0] op,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input int expEdges, input logic [N-1:0] expRes,
                        input logic [2*N-1:0] expX, input logic [4:0] expFlags);
      int edges;
      bit busySeen;
      applyStimulus(op, a, b);
      waitResult(edges, busySeen);
      checkOutput({tag, ".latency"}, 64'(edges), 64'(expEdges));
      if (expEdges > 0) checkOutput({tag, ".inReadyLow"}, 64'(busySeen), 64'(0));
      checkOutput({tag, ".results"}, 64'(results), 64'(expRes));
      checkOutput({tag, ".xresults"}, 64'(xresults), 64'(expX));
      checkOutput({tag, ".flags"}, 64'({carryflag, overflow, zeroflag, negflag, errflag}),
                  64'(expFlags));
      consume();
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      num1      = '0;
      num2      = '0;
      operation = '0;
      #12;
      checkOutput("reset.inReady", 64'(in_ready), 64'(1));
      checkOutput("reset.outValid", 64'(out_valid), 64'(0));
      checkOutput("reset.results", 64'(results), 64'(0));
      checkOutput("reset.xresults", 64'(xresults), 64'(0));
      checkOutput("reset.flags", 64'({carryflag, overflow, zeroflag, negflag, errflag}), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;

      runOp("add7F01", 5'h00, 8'h7F, 8'h01, 0, 8'h80, 16'h0000, 5'b01010);
      runOp("mulFFFF", 5'h04, 8'hFF, 8'hFF, N, 8'h01, 16'hFE01, 5'b00010);
      runOp("mul0D0B", 5'h04, 8'h0D, 8'h0B, N, 8'h8F, 16'h008F, 5'b00000);
      runOp("mulZero", 5'h04, 8'h00, 8'h55, N, 8'h00, 16'h0000, 5'b00100);
`ifdef SEQ_ALU_DIV_EN
      runOp("divu100by7", 5'h16, 8'h64, 8'h07, N, 8'h0E, 16'h020E, 5'b00000);
      runOp("remu100by7", 5'h17, 8'h64, 8'h07, N, 8'h02, 16'h020E, 5'b00000);
      runOp("remu200by3", 5'h17, 8'hC8, 8'h03, N, 8'h02, 16'h0242, 5'b00000);
      runOp("divu5by0", 5'h16, 8'h05, 8'h00, 0, 8'hFF, 16'h05FF, 5'b00011);
`else
      runOp("op16Illegal", 5'h16, 8'h64, 8'h07, 0, 8'h00, 16'h0000, 5'b00001);
      runOp("op17Illegal", 5'h17, 8'h64, 8'h07, 0, 8'h00, 16'h0000, 5'b00001);
`endif
      runOp("shlv01by0B", 5'h18, 8'h01, 8'h0B, 0, 8'h08, 16'h0000, 5'b00000);
      runOp("asrv80by2", 5'h19, 8'h80, 8'h02, 0, 8'hE0, 16'h0000, 5'b00010);
      runOp("incFF", 5'h02, 8'hFF, 8'h00, 0, 8'h00, 16'h0000, 5'b10100);
      runOp("dec00", 5'h03, 8'h00, 8'h00, 0, 8'hFF, 16'h0000, 5'b10010);
      runOp("sub8001", 5'h01, 8'h80, 8'h01, 0, 8'h7F, 16'h0000, 5'b01000);
      runOp("lt3of5", 5'h13, 8'h03, 8'h05, 0, 8'h01, 16'h0000, 5'b00000);
      runOp("ge3of5", 5'h14, 8'h03, 8'h05, 0, 8'h00, 16'h0000, 5'b00100);
      runOp("ror01", 5'h10, 8'h01, 8'h00, 0, 8'h80, 16'h0000, 5'b00010);
      runOp("asr81", 5'h0E, 8'h81, 8'h00, 0, 8'hC0, 16'h0000, 5'b00010);
      runOp("xnorF0CC", 5'h0A, 8'hF0, 8'hCC, 0, 8'hC3, 16'h0000, 5'b00010);
      runOp("op1F", 5'h1F, 8'h12, 8'h34, 0, 8'h00, 16'h0000, 5'b00001);

      // Backpressure: result held, no second accept while out_ready is low.
      begin
         int edges;
         bit busySeen;
         applyStimulus(5'h00, 8'h03, 8'h04);
         waitResult(edges, busySeen);
         checkOutput("bp.latency", 64'(edges), 64'(0));
         @(negedge clk);
         in_valid  = 1'b1;
         operation = 5'h00;
         num1      = 8'h09;
         num2      = 8'h09;
         for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp.results", 64'(results), 64'(8'h07));
            checkOutput("bp.outValid", 64'(out_valid), 64'(1));
            checkOutput("bp.inReady", 64'(in_ready), 64'(0));
         end
         in_valid = 1'b0;
         consume();
         checkOutput("bp.outValidAfter", 64'(out_valid), 64'(0));
         checkOutput("bp.inReadyAfter", 64'(in_ready), 64'(1));
         checkOutput("bp.resultsHeld", 64'(results), 64'(8'h07));
      end

      // Asynchronous reset at EXEC step 3 of a MUL aborts it at once.
      applyStimulus(5'h04, 8'hFF, 8'hFF);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("abort.busyBefore", 64'(in_ready), 64'(0));
      reset_n = 1'b0;
      #1;
      checkOutput("abort.outValid", 64'(out_valid), 64'(0));
      checkOutput("abort.inReady", 64'(in_ready), 64'(1));
      checkOutput("abort.results", 64'(results), 64'(0));
      checkOutput("abort.xresults", 64'(xresults), 64'(0));
      checkOutput("abort.flags", 64'({carryflag, overflow, zeroflag, negflag, errflag}), 64'(0));
      #1;
      reset_n = 1'b1;
      runOp("sub0001", 5'h01, 8'h00, 8'h01, 0, 8'hFF, 16'h0000, 5'b10010);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised ALU with valid/ready handshakes on input and output. It executes the established 5-bit opcode set plus iterative unsigned divide/remainder and variable shifts. Multiply and divide run as N-step shift-add / restoring sequences, so the block carries no N×N array. It sits between an operand-issuing controller and a result consumer, and accepts one operation at a time.

## Interface

- N, 8, operand width; power of two, ≥4.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept (high only in IDLE).
- num1  in  N  operand A.
- num2  in  N  operand B, or shift amount.
- operation  in  5  opcode.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- results  out  N  primary result.
- xresults  out  2N  wide result (MUL product; DIVU/REMU {remainder, quotient}); 0 otherwise.
- carryflag  out  1  carry out (ADD/INC) or borrow (SUB/DEC).
- overflow  out  1  signed overflow (ADD/SUB only).
- zeroflag  out  1  results==0 (MUL: xresults==0).
- negflag  out  1  results[N-1] (MUL: xresults[2N-1]).
- errflag  out  1  illegal opcode or divide by zero.

## Operation

- FSM states:
  - IDLE: in_ready=1. Handshake (in_valid&&in_ready at an edge) latches num1, num2 and operation.
  - From IDLE, MUL (0x04), DIVU and REMU go to EXEC; every other opcode computes and goes directly to DONE.
  - EXEC: one iteration per clock with a step counter 0..N-1. At step N-1 the result registers load and the state goes to DONE.
  - DONE: out_valid=1; all result and flag outputs held stable. Handshake (out_valid&&out_ready) returns to IDLE.
- Opcodes 0x00–0x15: ADD, SUB, INC, DEC, MUL, OR, AND, XOR, NOR, NAND, XNOR, NOT, SHL1, SHR1, ASR1, ROL1, ROR1, EQ, GT, LT, GE, LE.
  - Comparisons are unsigned; the result is zero-extended 0/1.
  - ADD/SUB use an (N+1)-bit intermediate; carryflag is bit N.
  - Overflow: ADD sets it when operand signs are equal and the result sign differs. SUB sets it when operand signs differ and the result sign differs from num1.
  - INC/DEC set carryflag on wrap (0xFF→0x00, 0x00→0xFF at N=8).
- New opcodes:
  - 0x16 DIVU: results=quotient.
  - 0x17 REMU: results=remainder.
  - 0x18 SHLV: num1 << (num2 mod N).
  - 0x19 ASRV: num1 >>> (num2 mod N).
- Divide by zero: completes in 1 cycle without EXEC. Quotient = all-ones, remainder = num1, errflag=1.
- Illegal opcodes (0x1A–0x1F): results, xresults and all flags 0 except errflag=1; 1 cycle.
- Each completion loads every output. Outputs not meaningful for the opcode load 0. After the output handshake, outputs hold until the next completion.
- Inputs are ignored outside an IDLE handshake; operand changes during EXEC have no effect.

## Timing

- Reset values: state IDLE, in_ready=1, out_valid=0, all result and flag outputs 0, step counter 0.
- Reset is asynchronous. Asserting it mid-EXEC or in DONE aborts the operation immediately, with no output handshake.
- Latency is measured from the input-handshake edge T0:
  - single-cycle ops and div-by-zero: out_valid high after T0+1.
  - MUL/DIVU/REMU: out_valid high after T0+N.
- Backpressure: DONE persists indefinitely while out_ready=0, and in_ready stays 0.
- No same-cycle accept in DONE: the earliest next input handshake is the edge after the output handshake. Throughput is one op per 2 cycles minimum.
- out_ready is ignored when out_valid=0.

## Configuration

- SEQ_ALU_DIV_EN defined: the divider datapath, the DIVU/REMU opcodes and div-by-zero handling are present.
- SEQ_ALU_DIV_EN undefined: the divider hardware is absent. 0x16/0x17 behave as illegal opcodes (errflag=1, results 0, 1-cycle latency). All other opcodes are unchanged.

## Test plan

- ADD 0x7F+0x01 (N=8) -> results=0x80, overflow=1, carryflag=0, negflag=1; out_valid one cycle after accept.
- MUL 0xFF×0xFF -> xresults=0xFE01, zeroflag=0; out_valid exactly 8 cycles after accept; in_ready=0 throughout.
- DIVU 100/7 (DIV_EN) -> results=0x0E, xresults=0x020E after 8 cycles. DIVU 5/0 -> results=0xFF, xresults=0x05FF, errflag=1 after 1 cycle.
- Backpressure: after ADD 0x03+0x04, hold out_ready=0 for 5 cycles while in_valid=1 -> results=0x07 stable, out_valid=1, in_ready=0, no second accept.
- reset_n low at EXEC step 3 of MUL -> out_valid=0, all outputs 0, in_ready=1 at once. A following SUB 0x00−0x01 -> results=0xFF, carryflag=1.
- SHLV 0x01 by 0x0B -> 0x08. Opcode 0x1F -> errflag=1, results=0. Without DIV_EN, 0x16 -> errflag=1 after 1 cycle.
